// File: rtl/wb_uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, frame shape,
// default baud divisors (common with the transmitter) and FIFO geometry.
package wb_uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_PUSH  = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  localparam int DEFAULT_BAUD_DIV_RATE  = 2604;
  localparam int DEFAULT_BAUD_DIV_WIDTH = 12;

  localparam int RX_FIFO_DW = 8;
  localparam int RX_FIFO_AW = 5;

endpackage

// File: rtl/wb_uart_rx_if.sv
// Reduced Wishbone pop bus plus the external FIFO memory port of the receiver.
interface wb_uart_rx_if
  import wb_uart_rx_pkg::*;
#(
  parameter int DW = RX_FIFO_DW,
  parameter int AW = RX_FIFO_AW
);

  logic          wb_cyc;
  logic          wb_stb;
  logic [DW-1:0] wb_data;
  logic          wb_ack;
  logic          wb_stall;

  logic [AW-1:0] fifo_mem_addr_w;
  logic [AW-1:0] fifo_mem_addr_r;
  logic          fifo_mem_we;
  logic [DW-1:0] fifo_mem_data_read;
  logic [DW-1:0] fifo_mem_data_write;

  modport master (
    output wb_cyc, wb_stb,
    input  wb_data, wb_ack, wb_stall,
    input  fifo_mem_addr_w, fifo_mem_addr_r, fifo_mem_we, fifo_mem_data_write,
    output fifo_mem_data_read
  );

  modport slave (
    input  wb_cyc, wb_stb,
    output wb_data, wb_ack, wb_stall,
    output fifo_mem_addr_w, fifo_mem_addr_r, fifo_mem_we, fifo_mem_data_write,
    input  fifo_mem_data_read
  );

endinterface

// File: rtl/wb_uart_rx_fifo.sv
// Wishbone-handshaked FIFO controller over an external memory with a
// registered (one-cycle) read port; acks arrive the cycle after the strobe.
module wb_fifo #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_cyc,
  input  logic          push_stb,
  input  logic [DW-1:0] push_data,
  output logic          push_ack,
  output logic          push_stall,
  input  logic          pop_cyc,
  input  logic          pop_stb,
  output logic [DW-1:0] pop_data,
  output logic          pop_ack,
  output logic          pop_stall,
  output logic [AW-1:0] mem_addr_w,
  output logic [AW-1:0] mem_addr_r,
  output logic          mem_we,
  output logic [DW-1:0] mem_data_write,
  input  logic [DW-1:0] mem_data_read
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push_cyc & push_stb & ~full;
  assign do_pop  = pop_cyc & pop_stb & ~empty;

  assign push_stall     = full;
  assign pop_stall      = empty;
  assign mem_we         = do_push;
  assign mem_addr_w     = wr_ptr;
  assign mem_data_write = push_data;
  // Memory reads rd_ptr every edge, so the popped word is on the bus with the ack.
  assign mem_addr_r     = rd_ptr;
  assign pop_data       = mem_data_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      push_ack <= 1'b0;
      pop_ack  <= 1'b0;
    end else begin
      push_ack <= do_push;
      pop_ack  <= do_pop;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver: 2-flop sync, centre-sampling FSM, bytes buffered in
// wb_fifo and popped over a reduced Wishbone interface.
module wb_uart_rx
  import wb_uart_rx_pkg::*;
#(
  parameter int BAUD_DIV_RATE  = DEFAULT_BAUD_DIV_RATE,
  parameter int BAUD_DIV_WIDTH = DEFAULT_BAUD_DIV_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  wb_uart_rx_if.slave  bus,
  input  logic         uart_rx,
  output logic         o_rx_avail,
  output logic         o_frame_err,
  output logic         o_overrun_err,
  input  logic         i_clear_err
);

  localparam int FIFO_DW   = RX_FIFO_DW;
  localparam int FIFO_AW   = RX_FIFO_AW;
  localparam int BIT_CNT_W = $clog2(UART_DATA_BITS + UART_STOP_BITS);

  localparam logic [BAUD_DIV_WIDTH-1:0] HALF_LOAD = BAUD_DIV_WIDTH'(BAUD_DIV_RATE / 2);
  localparam logic [BAUD_DIV_WIDTH-1:0] FULL_LOAD = BAUD_DIV_WIDTH'(BAUD_DIV_RATE - 1);
  localparam logic [BAUD_DIV_WIDTH-1:0] BAUD_ONE  = BAUD_DIV_WIDTH'(1);
  localparam logic [BIT_CNT_W-1:0]      BIT_ONE   = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]      LAST_BIT  = BIT_CNT_W'(UART_DATA_BITS - 1);

  rx_state_t                 state, state_nxt;
  logic [1:0]                sync;
  logic                      rx_prev;
  logic                      rx_s;
  logic [BAUD_DIV_WIDTH-1:0] baud_cnt, baud_nxt;
  logic [BIT_CNT_W-1:0]      bit_cnt, bit_nxt;
  logic [FIFO_DW-1:0]        shift_reg, shift_nxt;
  logic                      push_sent, sent_nxt;
  logic                      baud_zero;
  logic                      ferr_set;
  logic                      oerr_set;

  logic                      push_stb;
  logic                      push_ack;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop_stb;
  logic                      pop_cyc;

  assign rx_s      = sync[1];
  assign baud_zero = (baud_cnt == '0);

  // Synchronised falling edge is seen 2 cycles after the pin; the counter load
  // adds one more, so every sample lands at floor(R/2)+1 (+k*R) after the pin edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      sync          <= 2'b11;
      rx_prev       <= 1'b1;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      push_sent     <= 1'b0;
      o_frame_err   <= 1'b0;
      o_overrun_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      sync          <= {sync[0], uart_rx};
      rx_prev       <= rx_s;
      baud_cnt      <= baud_nxt;
      bit_cnt       <= bit_nxt;
      shift_reg     <= shift_nxt;
      push_sent     <= sent_nxt;
      o_frame_err   <= ferr_set | (o_frame_err & ~i_clear_err);
      o_overrun_err <= oerr_set | (o_overrun_err & ~i_clear_err);
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    sent_nxt  = push_sent;
    push_stb  = 1'b0;
    ferr_set  = 1'b0;
    oerr_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_nxt = ST_START;
          baud_nxt  = HALF_LOAD;
        end
      end
      ST_START: begin
        if (!baud_zero) begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end else if (!rx_s) begin
          state_nxt = ST_DATA;
          baud_nxt  = FULL_LOAD;
          bit_nxt   = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!baud_zero) begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end else begin
          shift_nxt = {rx_s, shift_reg[FIFO_DW-1:1]};
          baud_nxt  = FULL_LOAD;
          if (bit_cnt == LAST_BIT) state_nxt = ST_STOP;
          else                     bit_nxt   = bit_cnt + BIT_ONE;
        end
      end
      ST_STOP: begin
        if (!baud_zero) begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end else if (rx_s) begin
          state_nxt = ST_PUSH;
          sent_nxt  = 1'b0;
        end else begin
          ferr_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_PUSH: begin
        // One strobe cycle, then the ack the following cycle; two cycles total.
        if (!push_sent) begin
          if (fifo_full) begin
            oerr_set  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            push_stb = 1'b1;
            sent_nxt = 1'b1;
          end
        end else if (push_ack) begin
          sent_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pop_stb      = bus.wb_stb & ~fifo_empty;
  assign pop_cyc      = bus.wb_cyc & ~fifo_empty;
  assign bus.wb_stall = fifo_empty;
  assign o_rx_avail   = ~fifo_empty;

  wb_fifo #(
    .DW (FIFO_DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk            (i_clk),
    .rst_n          (i_reset_n),
    .push_cyc       (push_stb),
    .push_stb       (push_stb),
    .push_data      (shift_reg),
    .push_ack       (push_ack),
    .push_stall     (fifo_full),
    .pop_cyc        (pop_cyc),
    .pop_stb        (pop_stb),
    .pop_data       (bus.wb_data),
    .pop_ack        (bus.wb_ack),
    .pop_stall      (fifo_empty),
    .mem_addr_w     (bus.fifo_mem_addr_w),
    .mem_addr_r     (bus.fifo_mem_addr_r),
    .mem_we         (bus.fifo_mem_we),
    .mem_data_write (bus.fifo_mem_data_write),
    .mem_data_read  (bus.fifo_mem_data_read)
  );

endmodule
